// File: rtl/timer_prog.sv
// timer_prog: programmable timer with prescaler, periodic / one-shot modes.
// A load latches period N, prescale P and mode, then restarts the timer. A run
// expires after (N+1)*(P+1) enabled cycles and produces a one-cycle salida pulse.
// Control interface: load and stop are single-cycle strobes sampled on the
// rising clock edge. There is no backpressure. load beats stop, and stop beats
// counting. All outputs come straight from registers.
module timer_prog #(
  parameter int WIDTH   = 16,
  parameter int PRESC_W = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               load,
  input  logic               stop,
  input  logic               enable,
  input  logic               mode,
  input  logic [WIDTH-1:0]   period,
  input  logic [PRESC_W-1:0] prescale,
  output logic               salida,
  output logic [WIDTH-1:0]   count,
  output logic               running,
  output logic               done,
  output logic [1:0]         state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     count_q, count_d;
  logic [PRESC_W-1:0]   presc_q, presc_d;
  logic                 salida_q, salida_d;
  logic [WIDTH-1:0]     per_q, per_d;
  logic [PRESC_W-1:0]   pre_q, pre_d;
  logic                 mode_q, mode_d;

  // State, counters and latched configuration; async active-low clear.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      presc_q  <= '0;
      salida_q <= 1'b0;
      per_q    <= '0;
      pre_q    <= '0;
      mode_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      presc_q  <= presc_d;
      salida_q <= salida_d;
      per_q    <= per_d;
      pre_q    <= pre_d;
      mode_q   <= mode_d;
    end
  end

  // Next-state logic. salida defaults to 0, so only an expiry tick raises it.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    presc_d  = presc_q;
    salida_d = 1'b0;
    per_d    = per_q;
    pre_d    = pre_q;
    mode_d   = mode_q;
    if (load) begin
      per_d   = period;
      pre_d   = prescale;
      mode_d  = mode;
      count_d = '0;
      presc_d = '0;
      state_d = RUN;
    end else if (stop) begin
      count_d = '0;
      presc_d = '0;
      state_d = IDLE;
    end else begin
      case (state_q)
        RUN: begin
          // With enable low, everything holds. A pending expiry simply waits.
          if (enable) begin
            if (presc_q == pre_q) begin
              presc_d = '0;
              if (count_q == per_q) begin
                count_d  = '0;
                salida_d = 1'b1;
                if (mode_q) state_d = DONE;
              end else begin
                count_d = count_q + WIDTH'(1);
              end
            end else begin
              presc_d = presc_q + PRESC_W'(1);
            end
          end
        end
        IDLE, DONE: begin
          count_d = '0;
          presc_d = '0;
        end
        default: begin
          count_d = '0;
          presc_d = '0;
          state_d = IDLE;
        end
      endcase
    end
  end

  assign salida    = salida_q;
  assign count     = count_q;
  assign running   = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_timer_prog.sv
// tb_timer_prog: directed scenarios plus random traffic for timer_prog.
// The reference model counts enabled edges since the last load. It derives
// count and expiry from that number with plain division and modulo.
module tb_timer_prog;
  localparam int W  = 8;
  localparam int PW = 4;

  logic          clock    = 1'b0;
  logic          reset    = 1'b1;
  logic          load     = 1'b0;
  logic          stop     = 1'b0;
  logic          enable   = 1'b0;
  logic          mode     = 1'b0;
  logic [W-1:0]  period   = '0;
  logic [PW-1:0] prescale = '0;
  logic          salida, running, done;
  logic [W-1:0]  count;
  logic [1:0]    state_dbg;

  int errors = 0;
  int checks = 0;
  bit chk_on = 1'b0;
  logic [W-1:0] exp_q[$];

  // ---------------- clock / reset block ----------------
  always #5 clock = ~clock;

  timer_prog #(.WIDTH(W), .PRESC_W(PW)) dut (
    .clock(clock), .reset(reset), .load(load), .stop(stop), .enable(enable),
    .mode(mode), .period(period), .prescale(prescale), .salida(salida),
    .count(count), .running(running), .done(done), .state_dbg(state_dbg)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit     m_active = 1'b0;
  bit     m_finished = 1'b0;
  bit     m_sal = 1'b0;
  bit     m_mode = 1'b0;
  longint m_e = 0;
  int     m_n = 0;
  int     m_p = 0;

  always @(posedge clock or negedge reset) begin
    longint e_n;
    bit     hit;
    if (!reset) begin
      m_active <= 1'b0; m_finished <= 1'b0; m_sal <= 1'b0;
      m_e <= 0; m_n <= 0; m_p <= 0; m_mode <= 1'b0;
    end else if (load) begin
      m_n <= int'(period); m_p <= int'(prescale); m_mode <= mode;
      m_e <= 0; m_sal <= 1'b0; m_active <= 1'b1; m_finished <= 1'b0;
    end else if (stop) begin
      m_active <= 1'b0; m_finished <= 1'b0; m_e <= 0; m_sal <= 1'b0;
    end else if (m_active && enable) begin
      e_n = m_e + 1;
      hit = ((e_n % ((m_n + 1) * (m_p + 1))) == 0);
      m_sal <= hit;
      if (hit && m_mode) begin
        m_active <= 1'b0; m_finished <= 1'b1; m_e <= 0;
      end else begin
        m_e <= e_n;
      end
    end else begin
      m_sal <= 1'b0;
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clock) begin
    longint exp_cnt;
    if (chk_on) begin
      exp_cnt = m_active ? ((m_e / (m_p + 1)) % (m_n + 1)) : 0;
      chk("salida", salida, m_sal);
      chk("count", count, exp_cnt);
      chk("running", running, m_active);
      chk("done", done, m_finished);
      chk("state_dbg", state_dbg, m_finished ? 2 : (m_active ? 1 : 0));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic do_load(input int n, input int p, input bit m);
    load = 1'b1; period = W'(n); prescale = PW'(p); mode = m;
    tick();
    load = 1'b0;
  endtask

  task automatic wait_pulse(input int max, output int got);
    got = -1;
    for (int i = 1; i <= max; i++) begin
      tick();
      if (salida) begin
        got = i;
        break;
      end
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int got;
    #1 reset = 1'b0;
    #1 chk_on = 1'b1;
    chk("rst_salida", salida, 0);
    chk("rst_count", count, 0);
    chk("rst_running", running, 0);
    chk("rst_done", done, 0);
    @(negedge clock);
    reset = 1'b1;
    tick();

    // Full 8-bit range, P=0, periodic: pulses every 256 cycles.
    enable = 1'b1;
    exp_q.push_back(W'(0));
    exp_q.push_back(W'(0));
    do_load(255, 0, 1'b0);
    wait_pulse(300, got);
    chk("full_first", got, 256);
    chk("full_wrap_count", count, exp_q.pop_front());
    wait_pulse(300, got);
    chk("full_period", got, 256);
    chk("full_wrap_count2", count, exp_q.pop_front());

    // One-shot N=3, P=2: a single pulse after 12 cycles, then DONE.
    do_load(3, 2, 1'b1);
    wait_pulse(20, got);
    chk("oneshot_delay", got, 12);
    chk("oneshot_done", done, 1);
    chk("oneshot_running", running, 0);
    chk("oneshot_count", count, 0);
    wait_pulse(30, got);
    chk("oneshot_no_repeat", got, -1);

    // Enable gap at count=2 defers the expiry by exactly the gap length.
    do_load(4, 0, 1'b0);
    tick(); tick();
    chk("gap_count_before", count, 2);
    enable = 1'b0;
    repeat (5) tick();
    chk("gap_count_held", count, 2);
    enable = 1'b1;
    wait_pulse(20, got);
    chk("gap_resume", got, 3);

    // N=0, P=0: salida high every cycle, then stop clears it.
    do_load(0, 0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("n0_pulse", salida, 1);
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("stop_salida", salida, 0);
    chk("stop_running", running, 0);

    // A load on the expiry edge wins: no pulse, and the restart uses the new N.
    do_load(2, 0, 1'b0);
    tick(); tick();
    load = 1'b1; period = W'(1); prescale = '0; mode = 1'b0;
    tick();
    load = 1'b0;
    chk("load_on_exp_salida", salida, 0);
    chk("load_on_exp_count", count, 0);
    wait_pulse(10, got);
    chk("load_on_exp_next", got, 2);

    // Asynchronous reset mid-count: outputs clear before the next edge.
    do_load(20, 0, 1'b0);
    repeat (7) tick();
    chk("async_pre_count", count, 7);
    #2 reset = 1'b0;
    #1;
    chk("async_salida", salida, 0);
    chk("async_count", count, 0);
    chk("async_running", running, 0);
    chk("async_done", done, 0);
    @(negedge clock);
    reset = 1'b1;
    wait_pulse(10, got);
    chk("post_reset_no_pulse", got, -1);
    chk("post_reset_idle", running, 0);

    // Random traffic: the config inputs wander freely between loads.
    for (int i = 0; i < 1500; i++) begin
      load     = ($urandom_range(0, 19) == 0);
      stop     = ($urandom_range(0, 39) == 0);
      enable   = ($urandom_range(0, 9) < 8);
      mode     = 1'($urandom_range(0, 1));
      period   = W'($urandom_range(0, 6));
      prescale = PW'($urandom_range(0, 3));
      tick();
    end
    load = 1'b0; stop = 1'b0;
    tick();

    chk_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
